subservient_wb_loader: RTL

- Wishbone slave that sits between the Caravel management SoC bus and the subservient (SERV) core's byte-wide SRAM write port.
- Lets firmware on the management core load the subservient program, such as the blinky image, word by word. Each 32-bit word is serialized into four byte writes.
- Holds the subservient core in reset until firmware sets RUN. It is therefore the stage directly upstream of the subservient core and the GPIO it drives.

---
 rtl/subservient_wb_loader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/subservient_wb_loader.sv
// Wishbone slave that loads the subservient core's program RAM one word at a time.
// Each word is split into four byte writes, and the core is held in reset until RUN is set.
module subservient_wb_loader #(
  parameter int unsigned AW    = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic [AW-1:0] sram_waddr_o,
  output logic [7:0]    sram_wdata_o,
  output logic          sram_wen_o,
  output logic          core_rst_o
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_ADDR   = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ACK} state_t;

  state_t           r_state;
  logic             r_run;
  logic             r_err;
  logic [AW-1:0]    r_addr;
  logic [CNT_W-1:0] r_wcnt;
  logic [31:0]      r_word;
  logic [3:0]       r_sel;
  logic [1:0]       r_b;

  logic        w_req;
  logic        w_busy;
  logic [1:0]  w_reg;
  logic [1:0]  w_next_b;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic        w_unused;

  // A new access is only taken in IDLE and never while the previous ack is still high
  assign w_req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & (r_state == S_IDLE);
  assign w_busy   = (r_state != S_IDLE);
  assign w_reg    = wbs_adr_i[3:2];
  assign w_next_b = r_b + 2'd1;
  assign w_status = (32'(r_wcnt) << 16) | {30'd0, r_err, w_busy};
  assign w_unused = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

  always_comb begin
    w_rdata = 32'd0;
    case (w_reg)
      REG_CTRL:   w_rdata = {31'd0, r_run};
      REG_ADDR:   w_rdata = 32'(r_addr);
      REG_STATUS: w_rdata = w_status;
      default:    w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state      <= S_IDLE;
      r_run        <= 1'b0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_wcnt       <= '0;
      r_word       <= 32'd0;
      r_sel        <= 4'd0;
      r_b          <= 2'd0;
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= 32'd0;
      sram_waddr_o <= '0;
      sram_wdata_o <= 8'd0;
      sram_wen_o   <= 1'b0;
      core_rst_o   <= 1'b1;
    end else begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= 32'd0;
      sram_wen_o <= 1'b0;
      core_rst_o <= ~r_run;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (wbs_we_i && (w_reg == REG_DATA) && !r_run) begin
              // Byte 0 goes out on the same edge that accepts the word
              r_state      <= S_SHIFT;
              r_word       <= wbs_dat_i;
              r_sel        <= wbs_sel_i;
              r_b          <= 2'd0;
              sram_waddr_o <= r_addr;
              sram_wdata_o <= wbs_dat_i[7:0];
              sram_wen_o   <= wbs_sel_i[0];
            end else begin
              wbs_ack_o <= 1'b1;
              if (!wbs_we_i) begin
                wbs_dat_o <= w_rdata;
              end else begin
                case (w_reg)
                  REG_CTRL: r_run  <= wbs_dat_i[0];
                  REG_ADDR: r_addr <= {wbs_dat_i[AW-1:2], 2'b00};
                  REG_DATA: r_err  <= 1'b1;
                  default:  ;
                endcase
              end
            end
          end
        end
        S_SHIFT: begin
          if (r_b == 2'd3) begin
            r_state   <= S_ACK;
            wbs_ack_o <= 1'b1;
            r_addr    <= r_addr + AW'(4);
            r_wcnt    <= r_wcnt + CNT_W'(1);
          end else begin
            r_b          <= w_next_b;
            sram_waddr_o <= r_addr + AW'(w_next_b);
            sram_wdata_o <= r_word[{w_next_b, 3'b000} +: 8];
            sram_wen_o   <= r_sel[w_next_b];
          end
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
